// File: rtl/ra_2r1w_32x32_bist_pkg.sv
// Shared encodings, phase lengths and the expected-data rule for the 2R1W 32x32 march BIST.
package ra_2r1w_32x32_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR0,
      ST_RD0,
      ST_WR1,
      ST_RD1,
      ST_DRAIN,
      ST_DONE
   } bist_state_e;

   localparam logic PH_R0 = 1'b0;
   localparam logic PH_R1 = 1'b1;

   localparam logic [5:0] WR_PHASE_LEN = 6'd33;
   localparam logic [5:0] RD_PHASE_LEN = 6'd32;
   localparam logic [5:0] WR_LAST      = WR_PHASE_LEN - 6'd1;
   localparam logic [5:0] RD_LAST      = RD_PHASE_LEN - 6'd1;

   // E(a): base pattern, optionally XORed with the address replicated into every byte
   function automatic logic [0:31] exp_data(input logic [0:31] d, input logic sel,
                                            input logic [0:4] a);
      return d ^ (sel ? {4{3'b000, a}} : 32'h0);
   endfunction

endpackage

// File: rtl/ra_bist_chk.sv
// Per-read-port latency pipe and comparator: flags a miscompare when a tracked read returns.
module ra_bist_chk
   import ra_2r1w_32x32_bist_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        vld,
   input  logic [0:4]  adr,
   input  logic        phase,
   input  logic [0:31] rd_dat,
   input  logic [0:31] pattern,
   input  logic        pat_sel,
   output logic        err,
   output logic [0:4]  err_adr,
   output logic        err_phase
);

   typedef struct packed {
      logic       vld;
      logic [0:4] adr;
      logic       phase;
   } slot_t;

   slot_t       pipe [RD_LAT];
   slot_t       tail;
   logic [0:31] exp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {vld, adr, phase};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   // the tail slot lines up with the cycle in which the array presents that read's data
   always_comb begin
      tail      = pipe[RD_LAT-1];
      exp       = exp_data(pattern, pat_sel, tail.adr) ^ {32{tail.phase}};
      err       = tail.vld && (rd_dat != exp);
      err_adr   = tail.adr;
      err_phase = tail.phase;
   end

endmodule

// File: rtl/ra_2r1w_32x32_bist.sv
// March BIST initiator for the 2R1W 32x32 array wrapper: W(D) R(D) W(~D) R(~D) with
// registered array-side outputs, two read-port checkers and sticky fail status.
module ra_2r1w_32x32_bist
   import ra_2r1w_32x32_bist_pkg::*;
#(
   parameter int LATCHRD = 1,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             pat_sel,
   input  logic [0:31]      pattern,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [0:4]       fail_adr,
   output logic             fail_port,
   output logic             fail_phase,
   output logic             rd_enb_0,
   output logic             rd_enb_1,
   output logic [0:4]       rd_adr_0,
   output logic [0:4]       rd_adr_1,
   input  logic [0:31]      rd_dat_0,
   input  logic [0:31]      rd_dat_1,
   output logic             wr_enb_0,
   output logic [0:4]       wr_adr_0,
   output logic [0:31]      wr_dat_0
);

   localparam int         RD_LAT     = 1 + LATCHRD;
   localparam logic [5:0] DRAIN_LAST = 6'(RD_LAT - 1);

   bist_state_e state;
   logic [5:0]  cnt;
   logic [0:31] pattern_q;
   logic        pat_sel_q;
   logic        rd_phase;
   logic        accept, cmd_wr, cmd_rd, cmd_inv;
   logic [0:4]  a;
   logic        err0, err1, ph0, ph1;
   logic [0:4]  ad0, ad1;
   logic [CNT_W:0] cnt_sum;

   // start is a level sampled once per cycle; it is taken only in IDLE or once done is visible
   always_comb begin
      accept  = start && (state == ST_IDLE || (state == ST_DONE && done));
      cmd_wr  = (state == ST_WR0 || state == ST_WR1) && cnt != WR_LAST;
      cmd_rd  = state == ST_RD0 || state == ST_RD1;
      cmd_inv = state == ST_WR1 || state == ST_RD1;
      a       = cnt[4:0];
      cnt_sum = {1'b0, fail_cnt} + {{CNT_W{1'b0}}, err0} + {{CNT_W{1'b0}}, err1};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         pattern_q <= '0;
         pat_sel_q <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_phase  <= PH_R0;
         wr_enb_0  <= 1'b0;
         wr_adr_0  <= '0;
         wr_dat_0  <= '0;
         rd_enb_0  <= 1'b0;
         rd_enb_1  <= 1'b0;
         rd_adr_0  <= '0;
         rd_adr_1  <= '0;
      end else begin
         wr_enb_0 <= cmd_wr;
         wr_adr_0 <= cmd_wr ? a : '0;
         wr_dat_0 <= cmd_wr ? (exp_data(pattern_q, pat_sel_q, a) ^ {32{cmd_inv}}) : '0;
         rd_enb_0 <= cmd_rd;
         rd_enb_1 <= cmd_rd;
         rd_adr_0 <= cmd_rd ? a : '0;
         rd_adr_1 <= cmd_rd ? ~a : '0;
         rd_phase <= cmd_inv ? PH_R1 : PH_R0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  state     <= ST_WR0;
                  cnt       <= '0;
                  pattern_q <= pattern;
                  pat_sel_q <= pat_sel;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end else if (state == ST_DONE) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            ST_WR0, ST_WR1: begin
               cnt <= (cnt == WR_LAST) ? '0 : cnt + 6'd1;
               if (cnt == WR_LAST) state <= (state == ST_WR0) ? ST_RD0 : ST_RD1;
            end
            ST_RD0, ST_RD1: begin
               cnt <= (cnt == RD_LAST) ? '0 : cnt + 6'd1;
               if (cnt == RD_LAST) state <= (state == ST_RD0) ? ST_WR1 : ST_DRAIN;
            end
            ST_DRAIN: begin
               cnt <= (cnt == DRAIN_LAST) ? '0 : cnt + 6'd1;
               if (cnt == DRAIN_LAST) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   ra_bist_chk #(.RD_LAT(RD_LAT)) u_chk0 (
      .clk(clk), .reset_n(reset_n), .vld(rd_enb_0), .adr(rd_adr_0), .phase(rd_phase),
      .rd_dat(rd_dat_0), .pattern(pattern_q), .pat_sel(pat_sel_q),
      .err(err0), .err_adr(ad0), .err_phase(ph0)
   );

   ra_bist_chk #(.RD_LAT(RD_LAT)) u_chk1 (
      .clk(clk), .reset_n(reset_n), .vld(rd_enb_1), .adr(rd_adr_1), .phase(rd_phase),
      .rd_dat(rd_dat_1), .pattern(pattern_q), .pat_sel(pat_sel_q),
      .err(err1), .err_adr(ad1), .err_phase(ph1)
   );

   // first-fail fields latch once per run; port 0 wins a same-cycle tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fail       <= 1'b0;
         fail_cnt   <= '0;
         fail_adr   <= '0;
         fail_port  <= 1'b0;
         fail_phase <= 1'b0;
      end else if (accept) begin
         fail       <= 1'b0;
         fail_cnt   <= '0;
         fail_adr   <= '0;
         fail_port  <= 1'b0;
         fail_phase <= 1'b0;
      end else if (err0 || err1) begin
         fail     <= 1'b1;
         fail_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
         if (!fail) begin
            fail_port  <= !err0;
            fail_adr   <= err0 ? ad0 : ad1;
            fail_phase <= err0 ? ph0 : ph1;
         end
      end
   end

endmodule
